// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
// Shared types and constants for the wide-word to byte-stream serializer.
//   state_t : serializer FSM states (IDLE, SEND)
//   word_t  : FIFO payload {len, data}; len is valid byte count minus one
// -----------------------------------------------------------------------------
package serializer_pkg;

    localparam int unsigned BYTES_PER_WORD = 8;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned LEN_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [WORD_W-1:0] data;
    } word_t;

endpackage : serializer_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered count/full/empty flags. Pointers wrap
// modulo DEPTH (DEPTH must be a power of two). Push while full and pop while
// empty are ignored.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   push_i, wdata_i : write request and data
//   pop_i           : read request (head advances on the edge)
//   rdata_o         : current head entry
//   count_o         : number of entries held
//   full_o, empty_o : registered status flags
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule : sync_fifo

// File: rtl/wide_to_byte_serializer.sv
// -----------------------------------------------------------------------------
// wide_to_byte_serializer
// Queues 64-bit words (with a byte length) in a word FIFO and emits them
// LSB-first as a byte stream with a last flag on each word's final byte.
// Ports:
//   clk, reset_n                       : clock, async active-low reset
//   word_in_valid/ready/data/len       : word input handshake
//   stream_out_valid/ready/data/last   : byte output handshake
//   fifo_count                         : words queued (excluding active word)
//   busy                               : FSM is in SEND
//   bytes_sent                         : output handshake counter, present only
//                                        when SERIALIZER_STATS_EN is defined
// -----------------------------------------------------------------------------
module wide_to_byte_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    word_in_valid,
    output logic                    word_in_ready,
    input  logic [63:0]             word_in_data,
    input  logic [2:0]              word_in_len,
    output logic                    stream_out_valid,
    input  logic                    stream_out_ready,
    output logic [7:0]              stream_out_data,
    output logic                    stream_out_last,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    busy
`ifdef SERIALIZER_STATS_EN
    ,
    output logic [31:0]             bytes_sent
`endif
);

    state_t            state_q;
    logic [WORD_W-1:0] shift_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic              valid_q;
    logic              last_q;

    word_t             fifo_wdata;
    word_t             fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              out_hs;

    assign fifo_wdata = '{len: word_in_len, data: word_in_data};
    assign out_hs     = valid_q && stream_out_ready;
    // Pop when idle, or on the final byte's handshake so words run back to back
    assign fifo_pop   = !fifo_empty && ((state_q == IDLE) || (out_hs && last_q));

    sync_fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (word_in_valid),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Serializer FSM; all stream outputs come straight from these registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        state_q <= SEND;
                        shift_q <= fifo_head.data;
                        len_q   <= fifo_head.len;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= (fifo_head.len == '0);
                    end
                end
                SEND: begin
                    if (stream_out_ready) begin
                        if (!last_q) begin
                            shift_q <= shift_q >> BYTE_W;
                            idx_q   <= idx_q + LEN_W'(1);
                            last_q  <= ((idx_q + LEN_W'(1)) == len_q);
                        end else if (fifo_pop) begin
                            shift_q <= fifo_head.data;
                            len_q   <= fifo_head.len;
                            idx_q   <= '0;
                            last_q  <= (fifo_head.len == '0);
                        end else begin
                            state_q <= IDLE;
                            shift_q <= '0;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign word_in_ready    = !fifo_full;
    assign stream_out_valid = valid_q;
    assign stream_out_data  = shift_q[BYTE_W-1:0];
    assign stream_out_last  = last_q;
    assign busy             = (state_q == SEND);

`ifdef SERIALIZER_STATS_EN
    logic [31:0] bytes_sent_q;

    // Free-running handshake counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bytes_sent_q <= '0;
        end else if (out_hs) begin
            bytes_sent_q <= bytes_sent_q + 32'd1;
        end
    end

    assign bytes_sent = bytes_sent_q;
`endif

endmodule : wide_to_byte_serializer

// File: tb/tb_wide_to_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_wide_to_byte_serializer
// Directed self-checking bench for wide_to_byte_serializer (DEPTH = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wide_to_byte_serializer;

    localparam int unsigned DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   word_in_valid;
    logic                   word_in_ready;
    logic [63:0]            word_in_data;
    logic [2:0]             word_in_len;
    logic                   stream_out_valid;
    logic                   stream_out_ready;
    logic [7:0]             stream_out_data;
    logic                   stream_out_last;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   busy;
`ifdef SERIALIZER_STATS_EN
    logic [31:0]            bytes_sent;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wide_to_byte_serializer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .word_in_valid    (word_in_valid),
        .word_in_ready    (word_in_ready),
        .word_in_data     (word_in_data),
        .word_in_len      (word_in_len),
        .stream_out_valid (stream_out_valid),
        .stream_out_ready (stream_out_ready),
        .stream_out_data  (stream_out_data),
        .stream_out_last  (stream_out_last),
        .fifo_count       (fifo_count),
        .busy             (busy)
`ifdef SERIALIZER_STATS_EN
        ,
        .bytes_sent       (bytes_sent)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b, input logic l);
        chk({tag, "_valid"}, 64'(stream_out_valid), 64'd1);
        chk({tag, "_data"},  64'(stream_out_data),  64'(b));
        chk({tag, "_last"},  64'(stream_out_last),  64'(l));
    endtask

    logic [63:0] t3_data [5];
    logic [2:0]  t3_len  [5];
    logic [7:0]  t3_bytes[16];
    logic        t3_last [16];
    logic [7:0]  t2_bytes[3];

    initial begin
        t3_data  = '{64'h1716151413121110, 64'h2120, 64'h3130, 64'h4140, 64'h5150};
        t3_len   = '{3'd7, 3'd1, 3'd1, 3'd1, 3'd1};
        t3_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                     8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41, 8'h50, 8'h51};
        t3_last  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        t2_bytes = '{8'h0A, 8'h0B, 8'h0C};

        reset_n          = 1'b0;
        word_in_valid    = 1'b0;
        word_in_data     = '0;
        word_in_len      = '0;
        stream_out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid", 64'(stream_out_valid), 64'd0);
        chk("rst_last",  64'(stream_out_last),  64'd0);
        chk("rst_data",  64'(stream_out_data),  64'd0);
        chk("rst_count", 64'(fifo_count),       64'd0);
        chk("rst_busy",  64'(busy),             64'd0);
        chk("rst_ready", 64'(word_in_ready),    64'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Full 8-byte word, two-edge latency to first byte
        word_in_data     = 64'h0807060504030201;
        word_in_len      = 3'd7;
        word_in_valid    = 1'b1;
        stream_out_ready = 1'b1;
        @(negedge clk);
        word_in_valid = 1'b0;
        chk("t1_count_after_push", 64'(fifo_count), 64'd1);
        chk("t1_not_yet_valid",    64'(stream_out_valid), 64'd0);
        @(negedge clk);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 8; k++) begin
            expect_byte("t1", 8'(k + 1), (k == 7));
            @(negedge clk);
        end
        chk("t1_idle_valid", 64'(stream_out_valid), 64'd0);
        chk("t1_idle_busy",  64'(busy), 64'd0);

        // Short word: bytes beyond len never appear
        word_in_data  = 64'hFFFFFFFFFF0C0B0A;
        word_in_len   = 3'd2;
        word_in_valid = 1'b1;
        @(negedge clk);
        word_in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            expect_byte("t2", t2_bytes[k], (k == 2));
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            chk("t2_no_extra", 64'(stream_out_valid), 64'd0);
            @(negedge clk);
        end

        // Fill the FIFO with output stalled
        stream_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready_before_push", 64'(word_in_ready), 64'd1);
            word_in_data  = t3_data[i];
            word_in_len   = t3_len[i];
            word_in_valid = 1'b1;
            @(negedge clk);
            if (i > 0) expect_byte("t3_hold", 8'h10, 1'b0);
        end
        chk("t3_full_count", 64'(fifo_count),    64'd4);
        chk("t3_full_ready", 64'(word_in_ready), 64'd0);
        word_in_data = 64'h6160;
        word_in_len  = 3'd1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_refused_count", 64'(fifo_count),    64'd4);
            chk("t3_refused_ready", 64'(word_in_ready), 64'd0);
            expect_byte("t3_hold_full", 8'h10, 1'b0);
        end
        word_in_valid    = 1'b0;
        stream_out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            expect_byte("t3_drain", t3_bytes[j], t3_last[j]);
            @(negedge clk);
        end
        chk("t3_drained_valid", 64'(stream_out_valid), 64'd0);
        chk("t3_drained_count", 64'(fifo_count),       64'd0);
        chk("t3_drained_ready", 64'(word_in_ready),    64'd1);

        // Back-to-back words, no bubble between them
        word_in_data  = 64'hA1A0;
        word_in_len   = 3'd1;
        word_in_valid = 1'b1;
        @(negedge clk);
        word_in_data  = 64'hB0;
        word_in_len   = 3'd0;
        @(negedge clk);
        word_in_valid = 1'b0;
        expect_byte("t4_a0", 8'hA0, 1'b0);
        @(negedge clk);
        expect_byte("t4_a1", 8'hA1, 1'b1);
        @(negedge clk);
        expect_byte("t4_b0", 8'hB0, 1'b1);
        @(negedge clk);
        chk("t4_idle", 64'(stream_out_valid), 64'd0);

        // Reset mid-word discards active and queued words
        word_in_data  = 64'h0807060504030201;
        word_in_len   = 3'd7;
        word_in_valid = 1'b1;
        @(negedge clk);
        word_in_data  = 64'h99;
        word_in_len   = 3'd0;
        @(negedge clk);
        word_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_byte("t5_pre", 8'(k + 1), 1'b0);
            @(negedge clk);
        end
        chk("t5_queued_count", 64'(fifo_count), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(stream_out_valid), 64'd0);
        chk("t5_rst_count", 64'(fifo_count),       64'd0);
        chk("t5_rst_data",  64'(stream_out_data),  64'd0);
        chk("t5_rst_last",  64'(stream_out_last),  64'd0);
        chk("t5_rst_busy",  64'(busy),             64'd0);
        chk("t5_rst_ready", 64'(word_in_ready),    64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t5_post_valid", 64'(stream_out_valid), 64'd0);
            chk("t5_post_count", 64'(fifo_count),       64'd0);
        end

`ifdef SERIALIZER_STATS_EN
        // Statistics counter and wrap
        chk("st_reset", 64'(bytes_sent), 64'd0);
        word_in_data  = 64'h0807060504030201;
        word_in_len   = 3'd7;
        word_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        word_in_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("st_24", 64'(bytes_sent), 64'd24);
        dut.bytes_sent_q = 32'hFFFFFFFE;
        word_in_data  = 64'h0201;
        word_in_len   = 3'd1;
        word_in_valid = 1'b1;
        @(negedge clk);
        word_in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("st_wrap", 64'(bytes_sent), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_wide_to_byte_serializer

// File: doc/wide_to_byte_serializer.md
WIDE_TO_BYTE_SERIALIZER -- requirements
Module: wide_to_byte_serializer

Interface
REQ-001 Parameter DEPTH, default 4, word-FIFO depth in entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 word_in_valid  input  1  upstream word present.
REQ-005 word_in_ready  output  1  block can accept a word this cycle.
REQ-006 word_in_data  input  64  packed word; byte k = bits [8k+7:8k].
REQ-007 word_in_len  input  3  number of valid bytes minus one (0 = 1 byte, 7 = 8 bytes).
REQ-008 stream_out_valid  output  1  byte present for the downstream byte stage.
REQ-009 stream_out_ready  input  1  downstream accepts the byte.
REQ-010 stream_out_data  output  8  current byte.
REQ-011 stream_out_last  output  1  current byte is the final valid byte of its word.
REQ-012 fifo_count  output  $clog2(DEPTH)+1  words held in the FIFO, excluding the word being serialized.
REQ-013 busy  output  1  high while the state machine is in SEND.

Function
REQ-014 A word SHALL be accepted on a rising edge where word_in_valid and word_in_ready are both high; {len, data} is written to the FIFO tail.
REQ-015 word_in_ready SHALL equal (fifo_count < DEPTH), derived from registered state only; a full FIFO refuses a push even in a cycle where it pops.
REQ-016 The state machine SHALL have two states: IDLE and SEND.
REQ-017 IDLE: if fifo_count > 0, pop the head into the shift register and byte index (0), then go to SEND on the same edge; otherwise stay in IDLE.
REQ-018 SEND: stream_out_valid = 1; stream_out_data = shift[7:0]; stream_out_last = (index == len).
REQ-019 On a SEND handshake with last low, the shift register SHALL shift right by 8 bits and the index SHALL increment.
REQ-020 On a SEND handshake with last high, the next word SHALL be popped on the same edge if the FIFO is non-empty (no bubble); otherwise the state returns to IDLE.
REQ-021 While stream_out_valid is high and stream_out_ready is low, stream_out_data and stream_out_last SHALL hold stable.
REQ-022 Latency: a word pushed into an empty, idle block at edge N SHALL present its first byte from edge N+1 (pop edge) onward, so the byte is valid in the cycle after N+1.
REQ-023 Sustained throughput SHALL be one byte per cycle while stream_out_ready stays high.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-025 Bytes beyond len in word_in_data SHALL never appear on stream_out_data.

Reset
REQ-026 While reset_n is low: state = IDLE; FIFO empty; fifo_count = 0; stream_out_valid = 0; stream_out_last = 0; stream_out_data = 0; busy = 0; word_in_ready = 1.
REQ-027 Reset asserted mid-word SHALL discard the partial word and all queued words; no byte is emitted after deassertion until a new push.

Configuration
REQ-028 With macro SERIALIZER_STATS_EN defined, the block SHALL add output bytes_sent (32 bits, reset 0). It increments by 1 on every stream_out handshake and wraps from 0xFFFFFFFF to 0.
REQ-029 Without SERIALIZER_STATS_EN, the bytes_sent port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package serializer_pkg SHALL hold the state enum (IDLE, SEND), the packed struct word_t {len[2:0], data[63:0]}, and the localparam BYTES_PER_WORD = 8.
REQ-031 The word FIFO SHALL be a separate sub-module, sync_fifo, parameterized by width and DEPTH. Its count, full and empty outputs are all registered.

Verification
REQ-032 Push data 0x0807060504030201 with len 7, ready held high -> bytes 01..08 on consecutive cycles, last only on 08, first byte valid two edges after the push.
REQ-033 Push len 2, data 0xFFFFFFFFFF0C0B0A -> exactly bytes 0A, 0B, 0C with last on 0C; no FF byte is ever emitted.
REQ-034 Push five words with DEPTH=4 while stream_out_ready is held low -> word_in_ready drops after the fourth queued word; the output holds byte 0 of word 1 stable throughout.
REQ-035 Push two words back to back with ready held high -> last byte of word 1 is followed directly by first byte of word 2 with no idle cycle.
REQ-036 Assert reset_n low after byte 3 of an 8-byte word -> valid = 0 and fifo_count = 0 immediately; no further bytes appear after release.
REQ-037 With SERIALIZER_STATS_EN, send 3 full words -> bytes_sent = 24. Preload the counter to 0xFFFFFFFE, then send 2 bytes -> bytes_sent = 0.
